gbd_sram_tile_writer: RTL

GBD_SRAM_TILE_WRITER -- requirements
Module: gbd_sram_tile_writer

---
 rtl/gbd_sram_tile_writer_if.sv | 24 ++
 rtl/gbd_sram_tile_writer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gbd_sram_tile_writer_if.sv
// SRAM write port and tile-buffer read port of the tile writer.
// The writer is the master; the SRAM/buffer side is the slave.
interface gbd_sram_tile_writer_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned BUF_AW = 10
);
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_ncs;
    logic              ram_nwe;
    logic              buf_req;
    logic [BUF_AW-1:0] buf_addr;
    logic [7:0]        buf_data;

    modport master (
        output ram_addr, ram_data, ram_ncs, ram_nwe, buf_req, buf_addr,
        input  buf_data
    );

    modport slave (
        input  ram_addr, ram_data, ram_ncs, ram_nwe, buf_req, buf_addr,
        output buf_data
    );
endinterface

// File: rtl/gbd_sram_tile_writer.sv
// Reads byte pairs from a row buffer, splits them into even/odd bit planes and
// writes both planes to an asynchronous SRAM with fixed nWE pulse/recovery timing.
module gbd_sram_tile_writer #(
    parameter int unsigned ROW_BYTES = 32,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned ROUNDS    = 16,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BUF_AW    = 10,
    parameter int unsigned T_PULSE   = 6,
    parameter int unsigned T_RECOVER = 4
) (
    input  logic sys_clock,
    input  logic nAnyReset,
    input  logic start,
    input  logic clear,
    input  logic plane_swap,
    output logic busy,
    output logic done,
    output logic frame_done,
    gbd_sram_tile_writer_if.master mem
);
    localparam int unsigned XW   = $clog2(ROW_BYTES);
    localparam int unsigned YW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned RW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned TMAX = (T_PULSE > T_RECOVER) ? T_PULSE : T_RECOVER;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [ADDR_W-1:0] BLK_SIZE = ADDR_W'(ROWS * ROW_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_A, S_REQ_B, S_CAP_B, S_W0_PULSE, S_W0_REC, S_W1_PULSE, S_W1_REC
    } state_t;

    state_t            r_state, w_state_next;
    logic [TW-1:0]     r_tcnt;
    logic              w_t_end;
    logic [XW-1:0]     r_x, w_x_next;
    logic [YW-1:0]     r_y, w_y_next;
    logic              w_last_pair;
    logic [RW-1:0]     r_round;
    logic [ADDR_W-1:0] r_wcnt, r_ram_addr, w_base;
    logic [7:0]        r_ram_data, r_a, r_second, w_plane0, w_plane1;
    logic              r_swap, r_ram_ncs, r_ram_nwe, r_buf_req, r_done, r_frame_done;
    logic [BUF_AW-1:0] r_buf_addr, w_pair_addr;

    assign w_last_pair = (r_x == XW'(ROW_BYTES - 2)) && (r_y == YW'(ROWS - 1));
    assign w_x_next    = (r_y == YW'(ROWS - 1)) ? r_x + XW'(2) : r_x;
    assign w_y_next    = (r_y == YW'(ROWS - 1)) ? '0 : r_y + YW'(1);
    assign w_pair_addr = BUF_AW'(w_y_next) * BUF_AW'(ROW_BYTES) + BUF_AW'(w_x_next);
    assign w_base      = ADDR_W'(r_round) * BLK_SIZE;

    // A is the registered first byte; B is taken straight off the buffer in CAP_B.
    assign w_plane0 = {r_a[6], r_a[4], r_a[2], r_a[0],
                       mem.buf_data[6], mem.buf_data[4], mem.buf_data[2], mem.buf_data[0]};
    assign w_plane1 = {r_a[7], r_a[5], r_a[3], r_a[1],
                       mem.buf_data[7], mem.buf_data[5], mem.buf_data[3], mem.buf_data[1]};

    always_ff @(posedge sys_clock or negedge nAnyReset) begin
        if (!nAnyReset) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_t_end      = 1'b0;
        case (r_state)
            S_W0_PULSE, S_W1_PULSE: w_t_end = (r_tcnt == TW'(T_PULSE - 1));
            S_W0_REC, S_W1_REC:     w_t_end = (r_tcnt == TW'(T_RECOVER - 1));
            default: ;
        endcase
        case (r_state)
            S_IDLE:     if (start) w_state_next = S_REQ_A;
            S_REQ_A:    w_state_next = S_REQ_B;
            S_REQ_B:    w_state_next = S_CAP_B;
            S_CAP_B:    w_state_next = S_W0_PULSE;
            S_W0_PULSE: if (w_t_end) w_state_next = S_W0_REC;
            S_W0_REC:   if (w_t_end) w_state_next = S_W1_PULSE;
            S_W1_PULSE: if (w_t_end) w_state_next = S_W1_REC;
            S_W1_REC:   if (w_t_end) w_state_next = w_last_pair ? S_IDLE : S_REQ_A;
            default:    w_state_next = S_IDLE;
        endcase
        if (clear) w_state_next = S_IDLE;
    end

    always_ff @(posedge sys_clock or negedge nAnyReset) begin
        if (!nAnyReset) begin
            r_tcnt       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_round      <= '0;
            r_wcnt       <= '0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_a          <= '0;
            r_second     <= '0;
            r_swap       <= 1'b0;
            r_ram_ncs    <= 1'b1;
            r_ram_nwe    <= 1'b1;
            r_buf_req    <= 1'b0;
            r_buf_addr   <= '0;
            r_done       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_tcnt       <= '0;
            r_round      <= '0;
            r_ram_ncs    <= 1'b1;
            r_ram_nwe    <= 1'b1;
            r_buf_req    <= 1'b0;
            r_done       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_frame_done <= 1'b0;
            r_tcnt       <= (r_state == S_IDLE || w_state_next != r_state) ? '0 : r_tcnt + TW'(1);
            // nWE tracks the state being entered so it is a clean registered pulse.
            r_ram_nwe    <= !(w_state_next == S_W0_PULSE || w_state_next == S_W1_PULSE);
            case (r_state)
                S_IDLE: if (start) begin
                    r_swap     <= plane_swap;
                    r_x        <= '0;
                    r_y        <= '0;
                    r_wcnt     <= '0;
                    r_ram_addr <= w_base;
                    r_ram_ncs  <= 1'b0;
                    r_buf_req  <= 1'b1;
                    r_buf_addr <= '0;
                end
                S_REQ_A: r_buf_addr <= r_buf_addr + BUF_AW'(1);
                S_REQ_B: r_a <= mem.buf_data;
                S_CAP_B: begin
                    r_buf_req  <= 1'b0;
                    r_ram_data <= r_swap ? w_plane1 : w_plane0;
                    r_second   <= r_swap ? w_plane0 : w_plane1;
                end
                S_W0_REC: if (r_tcnt == '0) begin
                    r_wcnt     <= r_wcnt + ADDR_W'(1);
                    r_ram_addr <= w_base + r_wcnt + ADDR_W'(1);
                    r_ram_data <= r_second;
                end
                S_W1_REC: begin
                    if (r_tcnt == '0) begin
                        r_wcnt     <= r_wcnt + ADDR_W'(1);
                        r_ram_addr <= w_base + r_wcnt + ADDR_W'(1);
                    end
                    if (w_t_end) begin
                        if (w_last_pair) begin
                            r_done    <= 1'b1;
                            r_ram_ncs <= 1'b1;
                            if (r_round == RW'(ROUNDS - 1)) begin
                                r_round      <= '0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_round <= r_round + RW'(1);
                            end
                        end else begin
                            r_x        <= w_x_next;
                            r_y        <= w_y_next;
                            r_buf_addr <= w_pair_addr;
                            r_buf_req  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign frame_done   = r_frame_done;
    assign mem.ram_addr = r_ram_addr;
    assign mem.ram_data = r_ram_data;
    assign mem.ram_ncs  = r_ram_ncs;
    assign mem.ram_nwe  = r_ram_nwe;
    assign mem.buf_req  = r_buf_req;
    assign mem.buf_addr = r_buf_addr;
endmodule
